adder_feeder: RTL and testbench

//  Upstream sequencer for the 8-bit adder stage.
//  - Accepts one valid/ready stream of operand words from the host/TSIM side, alternating A then B.
//  - Buffers the words, drives a single-cycle a_valid pulse and then a b_valid pulse into the adder.
//  - Captures the adder's c_data and returns it on a valid/ready result stream.

---
 rtl/adder_feeder_pkg.sv | 18 +
 rtl/adder_feeder_fifo.sv | 75 +++++++
 rtl/adder_feeder.sv | 120 ++++++++++++
 tb/tb_adder_feeder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_feeder_pkg.sv
// Shared types and sizing helpers for the adder_feeder operand sequencer.
package adder_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE_A,
        DRIVE_B,
        SETTLE,
        RESULT
    } state_t;

    localparam int unsigned CNT_W = 32;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return unsigned'($clog2(depth));
    endfunction

endpackage

// File: rtl/adder_feeder_fifo.sv
// Synchronous operand FIFO with occupancy count; DEPTH must be a power of 2 so
// the pointers wrap naturally.
module adder_feeder_fifo
    import adder_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = ptr_width(DEPTH),
    localparam int unsigned CW    = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             ready
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Full refuses a push even when a pop frees a slot in the same cycle.
    always_comb begin
        do_push  = push && (count_q != FULL);
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign ready = (count_q != FULL);

    pop_not_empty: assert property (@(posedge clock) disable iff (!reset) pop |-> (count_q != '0));

endmodule

// File: rtl/adder_feeder.sv
// Operand sequencer for the adder stage: buffers A/B words, pulses them into the
// adder and returns the sum on a valid/ready stream. Optional ADDER_FEEDER_CNT_EN adds pair_count.
module adder_feeder
    import adder_feeder_pkg::*;
#(
    parameter int unsigned ADDER_BITS = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDER_BITS-1:0] in_data,
    output logic                  a_valid,
    output logic [ADDER_BITS-1:0] a_data,
    output logic                  b_valid,
    output logic [ADDER_BITS-1:0] b_data,
    input  logic [ADDER_BITS-1:0] c_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDER_BITS-1:0] out_data,
`ifdef ADDER_FEEDER_CNT_EN
    output logic [CNT_W-1:0]      pair_count,
`endif
    output logic                  busy
);

    localparam int unsigned   CW  = ptr_width(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] TWO = CW'(2);

    state_t                state_q, state_d;
    logic [ADDER_BITS-1:0] out_data_q, out_data_d;
    logic [ADDER_BITS-1:0] head;
    logic [CW-1:0]         count;
    logic                  pop;
    logic                  pair_ready;

    adder_feeder_fifo #(
        .WIDTH (ADDER_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .count (count),
        .ready (in_ready)
    );

    assign pair_ready = (count >= TWO);

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        pop        = 1'b0;
        a_valid    = 1'b0;
        a_data     = '0;
        b_valid    = 1'b0;
        b_data     = '0;
        out_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pair_ready) state_d = DRIVE_A;
            end
            DRIVE_A: begin
                a_valid = 1'b1;
                a_data  = head;
                pop     = 1'b1;
                state_d = DRIVE_B;
            end
            DRIVE_B: begin
                b_valid = 1'b1;
                b_data  = head;
                pop     = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: begin
                out_data_d = c_data;
                state_d    = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = pair_ready ? DRIVE_A : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;
    assign busy     = (state_q != IDLE);

`ifdef ADDER_FEEDER_CNT_EN
    logic [CNT_W-1:0] pair_count_q, pair_count_d;

    always_comb begin
        pair_count_d = pair_count_q;
        if (out_valid && out_ready) pair_count_d = pair_count_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pair_count_q <= '0;
        else        pair_count_q <= pair_count_d;
    end

    assign pair_count = pair_count_q;
`endif

endmodule

// File: tb/tb_adder_feeder.sv
// Scoreboard bench for adder_feeder with a behavioural 8-bit adder attached.
module tb_adder_feeder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic [7:0] c_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;
`ifdef ADDER_FEEDER_CNT_EN
    logic [31:0] pair_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_q[$];

    always #5 clock = ~clock;

    adder_feeder #(
        .ADDER_BITS (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .c_data    (c_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef ADDER_FEEDER_CNT_EN
        .pair_count(pair_count),
`endif
        .busy      (busy)
    );

    // Stand-in for the adder stage: registered operands, combinational sum.
    logic [7:0] reg_a = '0, reg_b = '0;
    always @(posedge clock) begin
        if (a_valid) reg_a <= a_data;
        if (b_valid) reg_b <= b_data;
    end
    assign c_data = reg_a + reg_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        int unsigned waited = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        check("push accepted in time", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_a_valid();
        int unsigned waited = 0;
        @(negedge clock);
        while (!a_valid && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check("a_valid seen", a_valid, 1);
    endtask

    task automatic drain();
        int unsigned waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        check("scoreboard drained", exp_q.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    // Monitor: compares every result handshake against the scoreboard.
    initial begin : monitor
        logic       stall_prev;
        logic [7:0] held;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("out_valid held under backpressure", out_valid, 1);
                    check("out_data held under backpressure", out_data, held);
                end
                if (!a_valid) check("a_data zero when idle", a_data, 0);
                if (!b_valid) check("b_data zero when idle", b_data, 0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected result: got %0d, expected no result", out_data);
                    end else begin
                        check("result", out_data, exp_q.pop_front());
                    end
                end
                stall_prev = out_valid && !out_ready;
                held       = out_data;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam int unsigned NBP = 10;
    logic [7:0] bp_words [NBP] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100};
    logic [7:0] bp_sums  [NBP/2] = '{8'd30, 8'd70, 8'd110, 8'd150, 8'd190};

    initial begin : stimulus
        // Reset
        repeat (3) @(negedge clock);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset a_valid", a_valid, 0);
        check("reset b_valid", b_valid, 0);
        check("reset busy", busy, 0);
        check("reset out_data", out_data, 0);
        reset = 1'b1;
        @(negedge clock);
        check("post-reset in_ready", in_ready, 1);
        check("post-reset out_valid", out_valid, 0);
        check("post-reset busy", busy, 0);
`ifdef ADDER_FEEDER_CNT_EN
        check("reset pair_count", pair_count, 0);
`endif

        // Basic 3 + 5 with pulse timing
        push_word(8'd3);
        push_word(8'd5);
        exp_q.push_back(8'd8);
        wait_a_valid();
        check("basic a_data", a_data, 3);
        check("basic busy", busy, 1);
        @(negedge clock);
        check("basic a_valid one pulse", a_valid, 0);
        check("basic b_valid", b_valid, 1);
        check("basic b_data", b_data, 5);
        @(negedge clock);
        check("basic settle b_valid low", b_valid, 0);
        check("basic settle out_valid low", out_valid, 0);
        @(negedge clock);
        check("basic out_valid latency", out_valid, 1);
        check("basic out_data", out_data, 8);
        drain();

        // Modulo wrap
        push_word(8'd200);
        push_word(8'd100);
        exp_q.push_back(8'd44);
        drain();

        // Backpressure
        @(posedge clock);
        #1 out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < NBP; i++) begin
                    push_word(bp_words[i]);
                    if (i % 2 == 1) exp_q.push_back(bp_sums[i/2]);
                end
            end
            begin
                repeat (30) @(negedge clock);
                check("backpressure in_ready low when full", in_ready, 0);
                check("backpressure out_valid", out_valid, 1);
                check("backpressure out_data", out_data, 30);
                repeat (5) @(negedge clock);
                check("backpressure in_ready still low", in_ready, 0);
                @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Lone odd word waits
        begin
            logic saw_a;
            saw_a = 1'b0;
            push_word(8'd7);
            repeat (20) begin
                @(negedge clock);
                if (a_valid) saw_a = 1'b1;
            end
            check("odd word no a_valid", saw_a, 0);
            check("odd word not busy", busy, 0);
        end
        push_word(8'd9);
        exp_q.push_back(8'd16);
        drain();

        // Reset during DRIVE_B discards the pair
        push_word(8'd40);
        push_word(8'd50);
        wait_a_valid();
        @(negedge clock);
        check("midreset in DRIVE_B", b_valid, 1);
        reset = 1'b0;
        #1;
        check("midreset a_valid", a_valid, 0);
        check("midreset b_valid", b_valid, 0);
        check("midreset b_data", b_data, 0);
        check("midreset out_valid", out_valid, 0);
        check("midreset busy", busy, 0);
        check("midreset out_data", out_data, 0);
        check("midreset in_ready", in_ready, 1);
`ifdef ADDER_FEEDER_CNT_EN
        check("midreset pair_count", pair_count, 0);
`endif
        repeat (3) @(negedge clock);
        reset = 1'b1;
        push_word(8'd1);
        push_word(8'd2);
        exp_q.push_back(8'd3);
        drain();
`ifdef ADDER_FEEDER_CNT_EN
        check("pair_count after one pair", pair_count, 1);
`endif

        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
